readline_avalon_burst: RTL and testbench

Downstream consumer of the readline link stage. Takes a held cache-line read request and issues one 4-beat Avalon-MM burst read of 32-bit words. Assembles the returned beats into a 128-bit line and returns it with a one-cycle done pulse. Sits between the readline link and the system memory interconnect.

---
 rtl/readline_avalon_burst_pkg.sv | 15 +
 rtl/readline_avalon_burst.sv | 109 ++++++++++
 tb/tb_readline_avalon_burst.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/readline_avalon_burst_pkg.sv
// Shared constants and state encoding for the readline Avalon burst reader.
package readline_avalon_burst_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE  = 2'd0,
      STATE_ISSUE = 2'd1,
      STATE_DATA  = 2'd2,
      STATE_DONE  = 2'd3
   } state_t;

   localparam int          LINE_BEATS      = 4;
   localparam logic [2:0]  BURSTCOUNT_LINE = 3'd4;
   localparam logic [3:0]  BYTEENABLE_ALL  = 4'hF;

endpackage

// File: rtl/readline_avalon_burst.sv
// Turns a held cache-line read request into one 4-beat Avalon-MM burst read
// and assembles the returned 32-bit beats into a 128-bit line.
module readline_avalon_burst
   import readline_avalon_burst_pkg::*;
#(
   parameter int BEAT_W = 32,
   parameter int BEATS  = LINE_BEATS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          readline_do,
   input  logic [31:0]   readline_address,
   output logic          readline_done,
   output logic [127:0]  readline_line,
   output logic [31:0]   avm_address,
   output logic          avm_read,
   output logic [2:0]    avm_burstcount,
   output logic [3:0]    avm_byteenable,
   input  logic          avm_waitrequest,
   input  logic          avm_readdatavalid,
   input  logic [31:0]   avm_readdata
);

   state_t              state_q;
   logic                avmRead_q;
   logic [31:0]         avmAddress_q;
   logic [1:0]          beatCnt_q;
   logic                done_q;
   logic [BEAT_W-1:0]   word_q [BEATS];

   logic                beatTake;
   logic                lastBeat;

   // Beats only count while a burst is outstanding; strays in IDLE or DONE are dropped.
   always_comb begin
      beatTake = avm_readdatavalid &&
                 ((state_q == STATE_ISSUE) || (state_q == STATE_DATA));
      lastBeat = beatTake && (beatCnt_q == 2'(BEATS - 1));
   end

   // Single FSM: command issue, beat capture into the line words, done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= STATE_IDLE;
         avmRead_q    <= 1'b0;
         avmAddress_q <= 32'd0;
         beatCnt_q    <= 2'd0;
         done_q       <= 1'b0;
         for (int k = 0; k < BEATS; k++) begin
            word_q[k] <= '0;
         end
      end else begin
         if (beatTake) begin
            word_q[beatCnt_q] <= avm_readdata;
            beatCnt_q         <= beatCnt_q + 2'd1;
         end
         case (state_q)
            STATE_IDLE: begin
               done_q <= 1'b0;
               if (readline_do && !done_q) begin
                  avmRead_q    <= 1'b1;
                  avmAddress_q <= {readline_address[31:4], 4'b0000};
                  beatCnt_q    <= 2'd0;
                  state_q      <= STATE_ISSUE;
               end
            end
            STATE_ISSUE: begin
               if (!avm_waitrequest) begin
                  avmRead_q <= 1'b0;
                  if (lastBeat) begin
                     done_q  <= 1'b1;
                     state_q <= STATE_DONE;
                  end else begin
                     state_q <= STATE_DATA;
                  end
               end
            end
            STATE_DATA: begin
               if (lastBeat) begin
                  done_q  <= 1'b1;
                  state_q <= STATE_DONE;
               end
            end
            STATE_DONE: begin
               done_q  <= 1'b0;
               state_q <= STATE_IDLE;
            end
            default: begin
               state_q <= STATE_IDLE;
            end
         endcase
      end
   end

   // Pack the captured words into the line, word k at bits [32k+31:32k].
   always_comb begin
      readline_line = '0;
      for (int k = 0; k < BEATS; k++) begin
         readline_line[k*BEAT_W +: BEAT_W] = word_q[k];
      end
   end

   assign readline_done  = done_q;
   assign avm_read       = avmRead_q;
   assign avm_address    = avmAddress_q;
   assign avm_burstcount = avmRead_q ? BURSTCOUNT_LINE : 3'd0;
   assign avm_byteenable = BYTEENABLE_ALL;

endmodule

// File: tb/tb_readline_avalon_burst.sv
// Directed bench for readline_avalon_burst: the bench plays both the upstream
// requester and the Avalon slave, cycle by cycle.
module tb_readline_avalon_burst;

   logic          clk;
   logic          rst;
   logic          readline_do;
   logic [31:0]   readline_address;
   logic          readline_done;
   logic [127:0]  readline_line;
   logic [31:0]   avm_address;
   logic          avm_read;
   logic [2:0]    avm_burstcount;
   logic [3:0]    avm_byteenable;
   logic          avm_waitrequest;
   logic          avm_readdatavalid;
   logic [31:0]   avm_readdata;

   int assertCount = 0;
   int failCount   = 0;
   int cmdCount    = 0;
   int doneCount   = 0;
   int cmdBase;
   int doneBase;

   readline_avalon_burst dut (
      .clk               (clk),
      .rst               (rst),
      .readline_do       (readline_do),
      .readline_address  (readline_address),
      .readline_done     (readline_done),
      .readline_line     (readline_line),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_burstcount    (avm_burstcount),
      .avm_byteenable    (avm_byteenable),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_readdata      (avm_readdata)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count accepted commands and done pulses as the interconnect would see them.
   always @(posedge clk) begin
      if (avm_read && !avm_waitrequest) cmdCount++;
      if (readline_done) doneCount++;
   end

   // Hard stop in case the directed sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive four back-to-back beats starting in the current cycle.
   task automatic applyStimulus(input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
      logic [31:0] beats [4];
      beats[0] = d0; beats[1] = d1; beats[2] = d2; beats[3] = d3;
      for (int i = 0; i < 4; i++) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = beats[i];
         checkOutput("no_early_done", readline_done, 1'b0);
         stepCycle();
      end
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'd0;
   endtask

   initial begin
      rst               = 1'b1;
      readline_do       = 1'b0;
      readline_address  = 32'd0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'd0;
      stepCycle();
      stepCycle();
      checkOutput("reset_read",  avm_read, 1'b0);
      checkOutput("reset_addr",  avm_address, 32'd0);
      checkOutput("reset_done",  readline_done, 1'b0);
      checkOutput("reset_line",  readline_line, 128'd0);
      checkOutput("reset_bcnt",  avm_burstcount, 3'd0);
      checkOutput("reset_be",    avm_byteenable, 4'hF);
      rst = 1'b0;
      stepCycle();

      // Basic read, minimum latency
      $display("[TB] basic read");
      cmdBase = cmdCount;
      readline_do      = 1'b1;
      readline_address = 32'h0001_2340;
      stepCycle();
      checkOutput("t1_read_c1",  avm_read, 1'b1);
      checkOutput("t1_addr_c1",  avm_address, 32'h0001_2340);
      checkOutput("t1_bcnt_c1",  avm_burstcount, 3'd4);
      readline_address = 32'hFFFF_FFF0;
      stepCycle();
      checkOutput("t1_read_c2",  avm_read, 1'b0);
      checkOutput("t1_bcnt_c2",  avm_burstcount, 3'd0);
      checkOutput("t1_addr_hold", avm_address, 32'h0001_2340);
      applyStimulus(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
      checkOutput("t1_done_c6",  readline_done, 1'b1);
      checkOutput("t1_line",     readline_line, 128'h44444444_33333333_22222222_11111111);
      readline_do = 1'b0;
      stepCycle();
      checkOutput("t1_done_c7",  readline_done, 1'b0);
      checkOutput("t1_read_c7",  avm_read, 1'b0);
      checkOutput("t1_cmds",     cmdCount - cmdBase, 1);

      // Alignment
      $display("[TB] alignment");
      readline_do      = 1'b1;
      readline_address = 32'h1234_567C;
      stepCycle();
      checkOutput("t2_addr",      avm_address, 32'h1234_5670);
      checkOutput("t2_line_hold", readline_line, 128'h44444444_33333333_22222222_11111111);
      stepCycle();
      applyStimulus(32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3);
      checkOutput("t2_done",  readline_done, 1'b1);
      checkOutput("t2_line",  readline_line, 128'h000000A3_000000A2_000000A1_000000A0);
      readline_do = 1'b0;
      stepCycle();

      // Stall for three cycles
      $display("[TB] waitrequest stall");
      cmdBase = cmdCount;
      readline_do      = 1'b1;
      readline_address = 32'h0000_0400;
      avm_waitrequest  = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         stepCycle();
         if (c == 4) avm_waitrequest = 1'b0;
         checkOutput("t3_read_stall", avm_read, 1'b1);
         checkOutput("t3_addr_stall", avm_address, 32'h0000_0400);
         checkOutput("t3_bcnt_stall", avm_burstcount, 3'd4);
      end
      stepCycle();
      checkOutput("t3_read_c5", avm_read, 1'b0);
      applyStimulus(32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003);
      checkOutput("t3_done_c9", readline_done, 1'b1);
      checkOutput("t3_line",    readline_line, 128'h55550003_55550002_55550001_55550000);
      checkOutput("t3_cmds",    cmdCount - cmdBase, 1);
      readline_do = 1'b0;
      stepCycle();

      // Gapped beats on cycles 3, 6, 7, 10
      $display("[TB] gapped beats");
      readline_do      = 1'b1;
      readline_address = 32'h0000_0600;
      stepCycle();
      begin
         logic [31:0] gapData [4];
         int          idx;
         gapData[0] = 32'hAAAA_000A; gapData[1] = 32'hBBBB_000B;
         gapData[2] = 32'hCCCC_000C; gapData[3] = 32'hDDDD_000D;
         idx = 0;
         for (int c = 1; c <= 10; c++) begin
            if (c == 3 || c == 6 || c == 7 || c == 10) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = gapData[idx];
               idx++;
            end else begin
               avm_readdatavalid = 1'b0;
               avm_readdata      = 32'd0;
            end
            checkOutput("t4_no_done", readline_done, 1'b0);
            stepCycle();
         end
      end
      avm_readdatavalid = 1'b0;
      checkOutput("t4_done_c11", readline_done, 1'b1);
      checkOutput("t4_line",     readline_line, 128'hDDDD000D_CCCC000C_BBBB000B_AAAA000A);
      readline_do = 1'b0;
      stepCycle();

      // Back-to-back: request held through DONE, then re-presented
      $display("[TB] back-to-back");
      cmdBase  = cmdCount;
      doneBase = doneCount;
      readline_do      = 1'b1;
      readline_address = 32'h0000_0800;
      stepCycle();
      stepCycle();
      applyStimulus(32'h6666_0000, 32'h6666_0001, 32'h6666_0002, 32'h6666_0003);
      checkOutput("t5_done1", readline_done, 1'b1);
      readline_address = 32'h0000_0100;
      stepCycle();
      checkOutput("t5_read_c7", avm_read, 1'b0);
      checkOutput("t5_done_c7", readline_done, 1'b0);
      stepCycle();
      checkOutput("t5_read_c8", avm_read, 1'b1);
      checkOutput("t5_addr_c8", avm_address, 32'h0000_0100);
      stepCycle();
      applyStimulus(32'h7777_0000, 32'h7777_0001, 32'h7777_0002, 32'h7777_0003);
      checkOutput("t5_done2", readline_done, 1'b1);
      checkOutput("t5_line2", readline_line, 128'h77770003_77770002_77770001_77770000);
      readline_do = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("t5_cmds",  cmdCount - cmdBase, 2);
      checkOutput("t5_dones", doneCount - doneBase, 2);

      // Reset after two beats, then a stray beat, then a normal request
      $display("[TB] reset mid-burst");
      doneBase = doneCount;
      readline_do      = 1'b1;
      readline_address = 32'h0000_2000;
      stepCycle();
      stepCycle();
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'h8888_0000;
      stepCycle();
      avm_readdata      = 32'h8888_0001;
      stepCycle();
      avm_readdatavalid = 1'b0;
      readline_do       = 1'b0;
      rst               = 1'b1;
      #1;
      checkOutput("t6_read_rst", avm_read, 1'b0);
      checkOutput("t6_line_rst", readline_line, 128'd0);
      stepCycle();
      rst = 1'b0;
      stepCycle();
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEAD_BEEF;
      stepCycle();
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'd0;
      checkOutput("t6_line_stray", readline_line, 128'd0);
      checkOutput("t6_read_idle",  avm_read, 1'b0);
      checkOutput("t6_no_done",    doneCount - doneBase, 0);
      readline_do      = 1'b1;
      readline_address = 32'h0000_3000;
      stepCycle();
      checkOutput("t6_addr_new", avm_address, 32'h0000_3000);
      stepCycle();
      applyStimulus(32'h9999_0000, 32'h9999_0001, 32'h9999_0002, 32'h9999_0003);
      checkOutput("t6_done_new", readline_done, 1'b1);
      checkOutput("t6_line_new", readline_line, 128'h99990003_99990002_99990001_99990000);
      readline_do = 1'b0;
      stepCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
